multiple_arbiter: RTL and testbench
===================================

MULTIPLE_ARBITER -- requirements
Module: multiple_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1024, max status-poll cycles per operation (used only with MULTIPLE_ARBITER_TIMEOUT_EN).
REQ-002 iClk  input  1  single clock; all logic on rising edge.
REQ-003 iReset  input  1  synchronous, active-high reset.
REQ-004 iReq0 / iReq1  input  1 each  requester 0/1 wants an operation.
REQ-005 iOpnd0 / iOpnd1  input  128 each  operands packed {d,c,b,a}, a in [31:0].
REQ-006 iCtrl0 / iCtrl1  input  4 each  control code for the operation.
REQ-007 oGnt0 / oGnt1  output  1 each  one-cycle pulse; operands and control latched this cycle.
REQ-008 oDone0 / oDone1  output  1 each  one-cycle pulse; oResult/oErr valid.
REQ-009 oResult  output  32  result of the last completed operation, held until the next oDone.
REQ-010 oErr  output  1  last operation timed out, held with oResult.
REQ-011 oChipSelect_n, oWrite_n, oRead_n  output  1 each  active-low peripheral strobes.
REQ-012 oAddress  output  4  peripheral register address.
REQ-013 oData  output  32  peripheral write data.
REQ-014 iData  input  32  peripheral read data, valid the cycle after a read strobe.

Function
REQ-015 States: IDLE, WR_A, WR_B, WR_C, WR_D, WR_CTRL, POLL_RD, POLL_CHK, RES_RD, RES_CAP, WR_CLR, DONE.
REQ-016 IDLE: if a request is pending, the arbiter pulses the winner's oGnt, latches its iOpnd/iCtrl and owner id, and goes to WR_A the next cycle; otherwise it stays in IDLE.
REQ-017 Arbitration is round-robin: on a tie the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-018 Requests are sampled only in IDLE; iReq held high through DONE re-requests in the next IDLE.
REQ-019 WR_A..WR_D each last one cycle: oChipSelect_n=0, oWrite_n=0, oAddress=0..3, oData = latched a..d.
REQ-020 WR_CTRL lasts one cycle: write to address 4 with oData = {28'b0, latched ctrl}.
REQ-021 POLL_RD lasts one cycle: oChipSelect_n=0, oRead_n=0, oAddress=6.
REQ-022 POLL_CHK: if iData[0]=1, go to RES_RD; else return to POLL_RD.
REQ-023 RES_RD: read strobe at address 5; RES_CAP captures iData into oResult and clears oErr.
REQ-024 WR_CLR: write 0 to address 4; then DONE pulses oDone for the owner for one cycle and returns to IDLE.
REQ-025 Strobes are high in every state not listed as asserting them; read and write are never asserted together.
REQ-026 Minimum latency from oGnt to oDone is 11 cycles when status is ready at the first poll.

Reset
REQ-027 While iReset=1 at a clock edge, state shall go to IDLE, strobes shall be 1, and oAddress, oData, oResult, oErr, oGnt*, oDone* shall be 0.
REQ-028 Reset mid-operation shall abort it with no oDone, and the round-robin pointer shall return to requester 0.

Configuration
REQ-029 Macro MULTIPLE_ARBITER_TIMEOUT_EN defined: a poll counter cleared at WR_CTRL counts each POLL_CHK miss.
REQ-030 On reaching TIMEOUT the block shall go to WR_CLR with oResult=0 and oErr=1, and oDone shall still pulse.
REQ-031 Macro undefined: polling is unbounded, there is no counter logic, and oErr shall stay 0.

Verification
REQ-032 Req0 only, opnd {4,3,2,1}, ctrl=2, status ready at first poll -> writes addr0..4 with values 1,2,3,4,2, then write 0 to addr4; oDone0 11 cycles after oGnt0; oResult = peripheral addr5 value.
REQ-033 Req0 and Req1 high together from reset -> oGnt0 first, then oGnt1 after oDone0; with both still high, the next grant goes to requester 0.
REQ-034 Status ready after 3 misses -> POLL_RD/POLL_CHK loop runs 4 times; oDone is 6 cycles later than in REQ-032.
REQ-035 iReset asserted during WR_C -> strobes high the next cycle, no oDone, the next tie grants requester 0.
REQ-036 TIMEOUT_EN, TIMEOUT=8, status never ready -> 8 polls, then WR_CLR, oDone with oErr=1 and oResult=0.
REQ-037 TIMEOUT_EN undefined, status ready after 2000 polls -> normal completion with oErr=0.

Source files
------------

// File: rtl/multiple_arbiter.sv
// Two-requester round-robin front end that runs one operation at a time on a peripheral.
// Optional poll timeout is enabled with `define MULTIPLE_ARBITER_TIMEOUT_EN.
module multiple_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic         iReq0,
    input  logic         iReq1,
    input  logic [127:0] iOpnd0,
    input  logic [127:0] iOpnd1,
    input  logic [3:0]   iCtrl0,
    input  logic [3:0]   iCtrl1,
    output logic         oGnt0,
    output logic         oGnt1,
    output logic         oDone0,
    output logic         oDone1,
    output logic [31:0]  oResult,
    output logic         oErr,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [3:0]   oAddress,
    output logic [31:0]  oData,
    input  logic [31:0]  iData
);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_C, WR_D, WR_CTRL, POLL_RD, POLL_CHK,
        RES_RD, RES_CAP, WR_CLR, DONE
    } state_t;

    state_t        state, state_next;
    logic [127:0]  opnd;
    logic [3:0]    ctrl;
    logic          owner;
    logic          last_owner;
    logic          req_any;
    logic          win_id;
    logic          timed_out;

    // On a tie the requester that was not served last wins.
    assign req_any = iReq0 | iReq1;
    assign win_id  = (iReq0 && iReq1) ? ~last_owner : iReq1;

`ifdef MULTIPLE_ARBITER_TIMEOUT_EN
    logic [31:0] poll_cnt;
    logic        poll_miss;

    assign poll_miss = (state == POLL_CHK) && !iData[0];
    assign timed_out = poll_miss && (poll_cnt == '0);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            poll_cnt <= '0;
        end else if (state == WR_CTRL) begin
            poll_cnt <= 32'(TIMEOUT - 1);
        end else if (poll_miss && (poll_cnt != '0)) begin
            poll_cnt <= poll_cnt - 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state      <= IDLE;
            opnd       <= '0;
            ctrl       <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            oResult    <= '0;
            oErr       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_any) begin
                opnd       <= win_id ? iOpnd1 : iOpnd0;
                ctrl       <= win_id ? iCtrl1 : iCtrl0;
                owner      <= win_id;
                last_owner <= win_id;
            end
            if (state == RES_CAP) begin
                oResult <= iData;
                oErr    <= 1'b0;
            end else if (timed_out) begin
                oResult <= '0;
                oErr    <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_any) state_next = WR_A;
            WR_A:     state_next = WR_B;
            WR_B:     state_next = WR_C;
            WR_C:     state_next = WR_D;
            WR_D:     state_next = WR_CTRL;
            WR_CTRL:  state_next = POLL_RD;
            POLL_RD:  state_next = POLL_CHK;
            POLL_CHK: begin
                if (iData[0])       state_next = RES_RD;
                else if (timed_out) state_next = WR_CLR;
                else                state_next = POLL_RD;
            end
            RES_RD:   state_next = RES_CAP;
            RES_CAP:  state_next = WR_CLR;
            WR_CLR:   state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes, bus and pulses are decoded from state; reset forces them inactive.
    always_comb begin
        oChipSelect_n = 1'b1;
        oWrite_n      = 1'b1;
        oRead_n       = 1'b1;
        oAddress      = '0;
        oData         = '0;
        oGnt0         = 1'b0;
        oGnt1         = 1'b0;
        oDone0        = 1'b0;
        oDone1        = 1'b0;
        if (!iReset) begin
            case (state)
                IDLE: begin
                    oGnt0 = req_any && !win_id;
                    oGnt1 = req_any && win_id;
                end
                WR_A, WR_B, WR_C, WR_D: begin
                    oChipSelect_n = 1'b0;
                    oWrite_n      = 1'b0;
                    case (state)
                        WR_A:    begin oAddress = 4'd0; oData = opnd[31:0];   end
                        WR_B:    begin oAddress = 4'd1; oData = opnd[63:32];  end
                        WR_C:    begin oAddress = 4'd2; oData = opnd[95:64];  end
                        default: begin oAddress = 4'd3; oData = opnd[127:96]; end
                    endcase
                end
                WR_CTRL: begin
                    oChipSelect_n = 1'b0;
                    oWrite_n      = 1'b0;
                    oAddress      = 4'd4;
                    oData         = {28'b0, ctrl};
                end
                POLL_RD: begin
                    oChipSelect_n = 1'b0;
                    oRead_n       = 1'b0;
                    oAddress      = 4'd6;
                end
                RES_RD: begin
                    oChipSelect_n = 1'b0;
                    oRead_n       = 1'b0;
                    oAddress      = 4'd5;
                end
                WR_CLR: begin
                    oChipSelect_n = 1'b0;
                    oWrite_n      = 1'b0;
                    oAddress      = 4'd4;
                end
                DONE: begin
                    oDone0 = !owner;
                    oDone1 = owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiple_arbiter.sv
// Bench for multiple_arbiter: peripheral model, table vectors, hand sequences and random ops.
module tb_multiple_arbiter;

`ifdef MULTIPLE_ARBITER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic         iClk = 1'b0;
    logic         iReset = 1'b1;
    logic         iReq0 = 1'b0, iReq1 = 1'b0;
    logic [127:0] iOpnd0 = '0, iOpnd1 = '0;
    logic [3:0]   iCtrl0 = '0, iCtrl1 = '0;
    logic         oGnt0, oGnt1, oDone0, oDone1, oErr;
    logic [31:0]  oResult, oData;
    logic         oChipSelect_n, oWrite_n, oRead_n;
    logic [3:0]   oAddress;
    logic [31:0]  iData = '0;

    multiple_arbiter #(.TIMEOUT(TO)) dut (
        .iClk(iClk), .iReset(iReset), .iReq0(iReq0), .iReq1(iReq1),
        .iOpnd0(iOpnd0), .iOpnd1(iOpnd1), .iCtrl0(iCtrl0), .iCtrl1(iCtrl1),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
        .oResult(oResult), .oErr(oErr), .oChipSelect_n(oChipSelect_n),
        .oWrite_n(oWrite_n), .oRead_n(oRead_n), .oAddress(oAddress),
        .oData(oData), .iData(iData)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic         r0, r1;
        logic [127:0] o0, o1;
        logic [3:0]   c0, c1;
        int           miss;
        logic [31:0]  rv;
        int           exp_win;
        int           exp_lat;
    } tv_t;

    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, polls = 0, misses = 0, done_cnt = 0, overlap_cnt = 0;
    int          rr_last = 1;
    logic [31:0] res_val = '0;
    wr_t         wlog[$];
    tv_t         tv[6];

    // Peripheral: status at addr 6 turns ready after 'misses' failed polls; result at addr 5.
    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if (oGnt0 || oGnt1) polls <= 0;
        if (!oChipSelect_n && !oRead_n) begin
            if (oAddress == 4'd6) begin
                iData <= {31'b0, (polls >= misses)};
                polls <= polls + 1;
            end else if (oAddress == 4'd5) begin
                iData <= res_val;
            end else begin
                iData <= 32'h5A5A_5A5A;
            end
        end else begin
            iData <= 32'hDEAD_BEEE;
        end
    end

    always @(negedge iClk) begin
        if (!oChipSelect_n && !oWrite_n) wlog.push_back('{oAddress, oData});
        if (!oWrite_n && !oRead_n) overlap_cnt++;
        if (oDone0 || oDone1) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic r0, input logic r1, input logic [127:0] o0,
                          input logic [127:0] o1, input logic [3:0] c0, input logic [3:0] c1,
                          input int miss, input logic [31:0] rv, input int exp_win,
                          input int exp_lat, input logic exp_err, input logic hold,
                          input string tag);
        int           win, g_cyc;
        logic         got_done;
        logic [127:0] op;
        logic [3:0]   c;
        misses = miss;
        res_val = rv;
        iOpnd0 = o0; iOpnd1 = o1; iCtrl0 = c0; iCtrl1 = c1;
        iReq0 = r0; iReq1 = r1;
        wlog.delete();
        #1;
        win = -1;
        for (int k = 0; k < 20; k++) begin
            if (oGnt0 || oGnt1) begin
                win = oGnt1 ? 1 : 0;
                break;
            end
            @(negedge iClk); #1;
        end
        g_cyc = cyc;
        chk({tag, "_grant"}, win, exp_win);
        if (win < 0) return;
        got_done = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge iClk); #1;
            if (k == 0 && !hold) begin iReq0 = 1'b0; iReq1 = 1'b0; end
            if (oDone0 || oDone1) begin got_done = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, got_done, 1);
        if (!got_done) return;
        chk({tag, "_done_owner"}, {oDone1, oDone0}, (win == 1) ? 2'b10 : 2'b01);
        chk({tag, "_latency"}, cyc - g_cyc, exp_lat);
        chk({tag, "_result"}, oResult, exp_err ? 32'd0 : rv);
        chk({tag, "_err"}, oErr, exp_err);
        op = (win == 1) ? o1 : o0;
        c  = (win == 1) ? c1 : c0;
        chk({tag, "_wr_count"}, wlog.size(), 6);
        if (wlog.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk({tag, "_wr_addr"}, wlog[k].a, (k < 4) ? k : 4);
                chk({tag, "_wr_data"}, wlog[k].d,
                    (k < 4) ? op[32*k +: 32] : ((k == 4) ? {28'b0, c} : 32'd0));
            end
        end
    endtask

    initial begin
        logic         found;
        int           d0, exp_w, miss;
        logic         r0, r1;
        logic [127:0] o0, o1;
        logic [31:0]  rv;

        tv[0] = '{1'b1, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'h77, 4'd2, 4'd9, 0, 32'hCAFE_0001, 0, 11};
        tv[1] = '{1'b1, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0, 4'd5, 4'd0, 3, 32'h1234_5678, 0, 17};
        tv[2] = '{1'b0, 1'b1, 128'h0, 128'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606_1717, 4'd0, 4'd7, 1, 32'h0BAD_CAFE, 1, 13};
        tv[3] = '{1'b1, 1'b1, 128'hFEED_0000_BEEF_0001_ABCD_0002_DCBA_0003, 128'h99, 4'd1, 4'd3, 0, 32'h8000_0001, 0, 11};
        tv[4] = '{1'b1, 1'b1, 128'h55, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 4'd6, 4'd12, 2, 32'h7FFF_FFFF, 1, 15};
        tv[5] = '{1'b0, 1'b1, 128'h0, {128{1'b1}}, 4'd0, 4'hF, 0, 32'hFFFF_FFFE, 1, 11};

        // Reset with both requesters asking: everything quiet.
        iReq0 = 1'b1; iReq1 = 1'b1;
        repeat (2) @(negedge iClk);
        #1;
        chk("rst_gnt", {oGnt1, oGnt0}, 2'b00);
        chk("rst_done", {oDone1, oDone0}, 2'b00);
        chk("rst_strobes", {oChipSelect_n, oWrite_n, oRead_n}, 3'b111);
        chk("rst_addr", oAddress, 0);
        chk("rst_data", oData, 0);
        chk("rst_result", oResult, 0);
        chk("rst_err", oErr, 0);
        iReset = 1'b0;

        // Both held high from reset: 0, then 1, then 0 again.
        run_op(1, 1, 128'h10, 128'h20, 4'd1, 4'd2, 0, 32'h0000_00A0, 0, 11, 0, 1, "tie_a");
        run_op(1, 1, 128'h10, 128'h20, 4'd1, 4'd2, 0, 32'h0000_00A1, 1, 11, 0, 1, "tie_b");
        run_op(1, 1, 128'h10, 128'h20, 4'd1, 4'd2, 0, 32'h0000_00A2, 0, 11, 0, 0, "tie_c");

        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].r0, tv[i].r1, tv[i].o0, tv[i].o1, tv[i].c0, tv[i].c1, tv[i].miss,
                   tv[i].rv, tv[i].exp_win, tv[i].exp_lat, 1'b0, 1'b0, $sformatf("tv%0d", i));
        end
        repeat (3) @(negedge iClk);
        #1;
        chk("result_hold", oResult, 32'hFFFF_FFFE);

        // Requester 0 served, then reset during WR_C: abort and pointer back to 0.
        misses = 0;
        iReq0 = 1'b1; iReq1 = 1'b0;
        #1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (oGnt0) begin found = 1'b1; break; end
            @(negedge iClk); #1;
        end
        chk("pre_reset_grant", found, 1);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iClk); #1;
            if (k == 0) iReq0 = 1'b0;
            if (!oChipSelect_n && !oWrite_n && oAddress == 4'd2) begin found = 1'b1; break; end
        end
        chk("reached_wr_c", found, 1);
        d0 = done_cnt;
        iReset = 1'b1;
        @(negedge iClk); #1;
        chk("abort_strobes", {oChipSelect_n, oWrite_n, oRead_n}, 3'b111);
        chk("abort_result", oResult, 0);
        chk("abort_err", oErr, 0);
        iReset = 1'b0;
        repeat (15) @(negedge iClk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        run_op(1, 1, 128'hAB, 128'hCD, 4'd3, 4'd4, 0, 32'h0000_0BB0, 0, 11, 0, 0, "post_reset_tie");
        rr_last = 0;

        // Random operations against the round-robin / latency model.
        for (int i = 0; i < 30; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            exp_w = (r0 && r1) ? (1 - rr_last) : (r1 ? 1 : 0);
            miss = $urandom_range(0, 5);
            rv = $urandom;
            o0 = {$urandom, $urandom, $urandom, $urandom};
            o1 = {$urandom, $urandom, $urandom, $urandom};
            run_op(r0, r1, o0, o1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), miss, rv,
                   exp_w, 11 + 2 * miss, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            rr_last = exp_w;
        end

`ifdef MULTIPLE_ARBITER_TIMEOUT_EN
        run_op(1, 0, 128'h1234, 128'h0, 4'd8, 4'd0, 1000000, 32'h5555_AAAA, 0, 23, 1'b1, 1'b0, "timeout");
`else
        run_op(1, 0, 128'h1234, 128'h0, 4'd8, 4'd0, 2000, 32'h5555_AAAA, 0, 4011, 1'b0, 1'b0, "long_poll");
`endif

        chk("rd_wr_overlap", overlap_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
